// File: rtl/tetris_tick_gen_if.sv
// Control/status bundle between the game FSM and the gravity tick generator.
interface tetris_tick_gen_if #(
    parameter int CNT_W = 32,
    parameter int LVL_W = 4
);
    logic [LVL_W-1:0] level;
    logic             fast;
    logic             pause;
    logic             restart;
    logic             tick;
    logic             anim_tick;
    logic [CNT_W-1:0] period_o;

    // game FSM side
    modport master (
        output level, fast, pause, restart,
        input  tick, anim_tick, period_o
    );

    // tick generator side
    modport slave (
        input  level, fast, pause, restart,
        output tick, anim_tick, period_o
    );
endinterface

// File: rtl/tetris_tick_gen.sv
// Gravity tick generator: level/soft-drop dependent period, pause/restart
// control, plus a free-running fixed-rate animation tick.
module tetris_tick_gen #(
    parameter int CNT_W       = 32,
    parameter int LVL_W       = 4,
    parameter int BASE_PERIOD = 80_000_000,
    parameter int LEVEL_STEP  = 6_000_000,
    parameter int MIN_PERIOD  = 8_000_000,
    parameter int FAST_SHIFT  = 3,
    parameter int ANIM_PERIOD = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    tetris_tick_gen_if.slave  bus
);
    // product is kept at full width so high levels never wrap into a long period
    localparam int PW = CNT_W + LVL_W;

    logic [PW-1:0]    prod;
    logic [PW-1:0]    diff;
    logic [CNT_W-1:0] slow;
    logic [CNT_W-1:0] shr;
    logic [CNT_W-1:0] eff;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] gcnt;
    logic [CNT_W-1:0] acnt;
    logic             tick_q;
    logic             anim_q;

    // period selection from level and soft-drop request
    always_comb begin
        prod = PW'(bus.level) * PW'(LEVEL_STEP);
        diff = PW'(BASE_PERIOD) - prod;
        if (prod >= PW'(BASE_PERIOD) || diff < PW'(MIN_PERIOD))
            slow = CNT_W'(MIN_PERIOD);
        else
            slow = diff[CNT_W-1:0];
        shr = slow >> FAST_SHIFT;
        if (!bus.fast)
            eff = slow;
        else if (shr < CNT_W'(2))
            eff = CNT_W'(2);
        else
            eff = shr;
    end

    // applied period register; the counter compares against this, not eff
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) period_q <= CNT_W'(BASE_PERIOD);
        else      period_q <= eff;
    end

    // gravity counter; >= lets a shrinking period fire next edge without wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcnt   <= '0;
            tick_q <= 1'b0;
        end else if (bus.restart) begin
            gcnt   <= '0;
            tick_q <= 1'b0;
        end else if (bus.pause) begin
            tick_q <= 1'b0;
        end else if (gcnt >= period_q - CNT_W'(1)) begin
            gcnt   <= '0;
            tick_q <= 1'b1;
        end else begin
            gcnt   <= gcnt + CNT_W'(1);
            tick_q <= 1'b0;
        end
    end

    // animation counter: fixed period, ignores pause, cleared by restart
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acnt   <= '0;
            anim_q <= 1'b0;
        end else if (bus.restart) begin
            acnt   <= '0;
            anim_q <= 1'b0;
        end else if (acnt >= CNT_W'(ANIM_PERIOD - 1)) begin
            acnt   <= '0;
            anim_q <= 1'b1;
        end else begin
            acnt   <= acnt + CNT_W'(1);
            anim_q <= 1'b0;
        end
    end

    assign bus.tick      = tick_q;
    assign bus.anim_tick = anim_q;
    assign bus.period_o  = period_q;
endmodule

// File: tb/tb_tetris_tick_gen.sv
// Randomized + directed bench for tetris_tick_gen against a cycle-level model.
module tb_tetris_tick_gen;
    localparam int CNT_W = 8;
    localparam int LVL_W = 3;
    localparam int BASE  = 20;
    localparam int STEP  = 4;
    localparam int MINP  = 6;
    localparam int SH    = 1;
    localparam int ANIM  = 5;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    tetris_tick_gen_if #(.CNT_W(CNT_W), .LVL_W(LVL_W)) bus ();
    tetris_tick_gen_if #(.CNT_W(CNT_W), .LVL_W(LVL_W)) bus2 ();

    tetris_tick_gen #(
        .CNT_W(CNT_W), .LVL_W(LVL_W), .BASE_PERIOD(BASE), .LEVEL_STEP(STEP),
        .MIN_PERIOD(MINP), .FAST_SHIFT(SH), .ANIM_PERIOD(ANIM)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    // second instance with a deep soft-drop shift to exercise the floor of 2
    tetris_tick_gen #(
        .CNT_W(CNT_W), .LVL_W(LVL_W), .BASE_PERIOD(BASE), .LEVEL_STEP(STEP),
        .MIN_PERIOD(MINP), .FAST_SHIFT(3), .ANIM_PERIOD(ANIM)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: applied period, elapsed counts, expected pulses
    int m_per;
    int m_g;
    int m_a;
    bit m_tick;
    bit m_anim;

    function automatic int exp_period(int lv, bit f, int sh);
        int p;
        p = BASE - lv * STEP;
        if (p < MINP) p = MINP;
        if (f) begin
            p = p / (1 << sh);
            if (p < 2) p = 2;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_per = BASE; m_g = 0; m_a = 0; m_tick = 0; m_anim = 0;
    endtask

    // one clock edge: model advances with the inputs present at the edge,
    // then all outputs are compared 1 time unit later
    task automatic cyc();
        int lv; bit f, p, r;
        lv = int'(bus.level); f = bus.fast; p = bus.pause; r = bus.restart;
        @(posedge clk);
        if (r) begin
            m_g = 0; m_tick = 0;
        end else if (p) begin
            m_tick = 0;
        end else if (m_g + 1 >= m_per) begin
            m_g = 0; m_tick = 1;
        end else begin
            m_g++; m_tick = 0;
        end
        if (r) begin
            m_a = 0; m_anim = 0;
        end else if (m_a + 1 >= ANIM) begin
            m_a = 0; m_anim = 1;
        end else begin
            m_a++; m_anim = 0;
        end
        m_per = exp_period(lv, f, SH);
        #1;
        chk("tick", int'(bus.tick), int'(m_tick));
        chk("anim_tick", int'(bus.anim_tick), int'(m_anim));
        chk("period_o", int'(bus.period_o), m_per);
    endtask

    // number of edges until tick is seen high (bounded)
    task automatic edges_to_tick(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            n++;
            if (bus.tick) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        cyc();
        bus.restart = 1'b0;
    endtask

    initial begin
        int n;
        n_chk = 0; n_pass = 0;
        rst = 1'b0;
        bus.level = '0; bus.fast = 1'b0; bus.pause = 1'b0; bus.restart = 1'b0;
        bus2.level = 3'd7; bus2.fast = 1'b1; bus2.pause = 1'b0; bus2.restart = 1'b0;
        model_reset();
        #12;
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_anim", int'(bus.anim_tick), 0);
        chk("rst_period", int'(bus.period_o), BASE);
        #1 rst = 1'b1;

        // level 0 free run: ticks after edges 20, 40, 60
        edges_to_tick(n); chk("first_tick", n, 20);
        edges_to_tick(n); chk("spacing_l0_a", n, 20);
        edges_to_tick(n); chk("spacing_l0_b", n, 20);
        chk("fast_floor_shift3", int'(bus2.period_o), 2);

        // level clamping
        bus.level = 3'd3; cyc(); cyc(); edges_to_tick(n);
        edges_to_tick(n); chk("spacing_l3", n, 8);
        bus.level = 3'd4; cyc(); cyc(); edges_to_tick(n);
        edges_to_tick(n); chk("spacing_l4", n, 6);
        bus.level = 3'd7; cyc(); cyc(); edges_to_tick(n);
        edges_to_tick(n); chk("spacing_l7", n, 6);
        bus.fast = 1'b1; cyc(); cyc(); edges_to_tick(n);
        edges_to_tick(n); chk("spacing_l7_fast", n, 3);
        bus.fast = 1'b0;

        // mid-count shrink: level 0, at gcnt=15 jump to level 3
        bus.level = 3'd0; cyc(); cyc(); pulse_restart();
        repeat (15) cyc();
        bus.level = 3'd3; cyc();
        chk("shrink_period", int'(bus.period_o), 8);
        chk("shrink_no_tick", int'(bus.tick), 0);
        cyc();
        chk("shrink_tick", int'(bus.tick), 1);
        edges_to_tick(n); chk("shrink_spacing", n, 8);
        bus.fast = 1'b1; cyc();
        chk("fast_period", int'(bus.period_o), 4);
        bus.fast = 1'b0; bus.level = 3'd0; cyc(); cyc();

        // pause 7 cycles at gcnt=10
        pulse_restart();
        repeat (10) cyc();
        bus.pause = 1'b1; repeat (7) cyc(); bus.pause = 1'b0;
        edges_to_tick(n); chk("pause_delay", n, 10);

        // restart while paused
        bus.pause = 1'b1; repeat (4) cyc();
        pulse_restart(); repeat (3) cyc();
        bus.pause = 1'b0;
        edges_to_tick(n); chk("restart_in_pause", n, 20);

        // async reset while tick is high
        edges_to_tick(n);
        #2 rst = 1'b0;
        #1;
        chk("arst_tick", int'(bus.tick), 0);
        chk("arst_anim", int'(bus.anim_tick), 0);
        chk("arst_period", int'(bus.period_o), BASE);
        model_reset();
        #1 rst = 1'b1;
        edges_to_tick(n); chk("arst_first_tick", n, 20);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) bus.level = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 14) == 0) bus.fast = ~bus.fast;
            bus.pause   = ($urandom_range(0, 7) == 0);
            bus.restart = ($urandom_range(0, 49) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tetris_tick_gen.md
# tetris_tick_gen

Parametrised gravity-tick generator for the Tetris game core. It produces a one-cycle `tick` pulse whose period depends on the current game level and a soft-drop `fast` request. It also provides pause and restart control, plus an independent fixed-rate `anim_tick` for blink and animation effects. The game FSM consumes `tick` to move the active piece down one row and `anim_tick` for display effects. It replaces the fixed 0.8 s divider.

## Interface
Parameters:
- `CNT_W`, 32, width of counters and of `period_o`
- `LVL_W`, 4, width of `level`
- `BASE_PERIOD`, 80_000_000, gravity period in cycles at level 0
- `LEVEL_STEP`, 6_000_000, period reduction per level
- `MIN_PERIOD`, 8_000_000, floor on slow-mode period; constraint: 2 ≤ `MIN_PERIOD` ≤ `BASE_PERIOD` < 2^`CNT_W`
- `FAST_SHIFT`, 3, soft-drop divides the period by 2^`FAST_SHIFT`
- `ANIM_PERIOD`, 25_000_000, animation tick period in cycles; constraint: ≥ 2

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `level`  in  `LVL_W`  current game level (unsigned)
- `fast`  in  1  soft-drop request, level-sensitive
- `pause`  in  1  freezes the gravity counter while high
- `restart`  in  1  synchronous clear of both counters (one-cycle pulse or held)
- `tick`  out  1  gravity pulse, exactly one cycle wide
- `anim_tick`  out  1  animation pulse, exactly one cycle wide
- `period_o`  out  `CNT_W`  currently applied gravity period in cycles

## Operation
- **Slow period (`slow`):**
  - Compute `prod` = `level` × `LEVEL_STEP` at full width (`CNT_W`+`LVL_W` bits, no truncation).
  - If `prod` ≥ `BASE_PERIOD`, or `BASE_PERIOD` − `prod` < `MIN_PERIOD`, then `slow` = `MIN_PERIOD`.
  - Otherwise `slow` = `BASE_PERIOD` − `prod`.
- **Effective period (`eff`):**
  - `fast`=1: `eff` = max(`slow` >> `FAST_SHIFT`, 2).
  - `fast`=0: `eff` = `slow`.
- `period_o` is a register loaded with `eff` on every clock edge. The gravity counter always compares against `period_o`, not against `eff`.
- **Gravity counter `gcnt`**, per edge in priority order:
  - `restart`=1: `gcnt`←0, `tick`←0. Takes precedence over `pause`.
  - `pause`=1: `gcnt` holds, `tick`←0.
  - `gcnt` ≥ `period_o`−1: `gcnt`←0, `tick`←1.
  - Otherwise: `gcnt`←`gcnt`+1, `tick`←0.
- The ≥ comparison handles a period shrinking below the current count (level-up, `fast` asserted): the tick fires on the next edge, with no wrap-around through 2^`CNT_W`.
- **Animation counter `acnt`:**
  - Same rule against the constant `ANIM_PERIOD`.
  - Ignores `pause`.
  - Cleared by `restart`.
- Both counters run continuously; there are no other states.

## Timing
- Reset (`rst`=0, asynchronous):
  - `tick`=0, `anim_tick`=0, `gcnt`=0, `acnt`=0.
  - `period_o`=`BASE_PERIOD`, the level-0 slow value.
- After reset release with constant inputs, the first `tick` is high after the P-th rising edge. After that, `tick` is high once every P cycles, where P = `period_o`.
- `level`/`fast` changes: `period_o` updates on the next edge. The new period governs the compare from the edge after that (2-edge latency from input to compare).
- Pause: a pause of N cycles delays the next `tick` by exactly N cycles. `tick` is never high in a cycle following a paused edge.
- Restart: the next `tick` occurs P edges after the restart edge. `anim_tick` behaves the same way with `ANIM_PERIOD`.
- If `pause` deasserts with `gcnt` ≥ `period_o`−1, `tick` fires on the first unpaused edge.
- Asserting `rst` mid-count forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
Bench parameters: `CNT_W`=8, `LVL_W`=3, `BASE_PERIOD`=20, `LEVEL_STEP`=4, `MIN_PERIOD`=6, `FAST_SHIFT`=1, `ANIM_PERIOD`=5.
- **Level 0, free-running:** release reset with `level`=0 → `period_o`=20; `tick` high after edge 20, 40, 60, each for exactly one cycle; `anim_tick` every 5 cycles.
- **Level clamping:** `level`=3 → `period_o`=8, tick spacing 8. `level`=4 → 6 (clamped to `MIN_PERIOD`). `level`=7 → 6 (28 > 20). Check spacing after each change settles.
- **Mid-count shrink:** at `level`=0, when `gcnt`=15 set `level`=3 → `period_o`=8 on the next edge, `tick` on the following edge, then spacing 8. Then `fast`=1 → `period_o`=4 (`slow`=8 >> 1).
- **Fast floor:** `level`=7 with `fast`=1 → `period_o`=3. Rebuild the bench with `FAST_SHIFT`=3 → `period_o`=2 (floor).
- **Pause and restart:** `level`=0, assert `pause` for 7 cycles at `gcnt`=10 → next `tick` 7 cycles late, while `anim_tick` keeps its 5-cycle cadence. Pulse `restart` with `pause`=1 → `gcnt`=0, `acnt`=0, and the next `tick` comes 20 edges after `pause` drops.
- **Asynchronous reset:** drop `rst` between clock edges while `tick`=1 → `tick`, `anim_tick` fall and `period_o`=20 without a clock edge. After release, the first `tick` comes after edge 20.
